card_pick_controller: RTL
=========================

// Module: card_pick_controller
// PURPOSE
//  Game-play stage downstream of the card color memory and mouse controller. While the card
//  screen is active, it converts left-click edges into card indices on the 5x3 grid, reveals
//  picks, reads both colors from the regfile and compares them. It then marks pairs matched or
//  hides them after a delay, and drives the revealed/matched masks consumed by draw_cards.
// PARAMETERS
//  CARDS_X     5         grid columns
//  CARDS_Y     3         grid rows
//  GRID_X0     57        x of left edge of column 0, pixels
//  GRID_Y0     44        y of top edge of row 0, pixels
//  CARD_W      150       card width, pixels
//  CARD_H      200       card height, pixels
//  GAP         40        spacing between cards, pixels (x and y)
//  NUM_PAIRS   7         matches needed for game_over
//  HIDE_DELAY  65000000  cycles a mismatched pair stays visible (1 s @ 65 MHz)
// PORTS
//  pclk         in   1   65 MHz pixel clock
//  rst          in   1   asynchronous, active-low reset
//  enable       in   1   high while state machine is in draw_cards
//  xpos         in   12  mouse x
//  ypos         in   12  mouse y
//  left         in   1   mouse left button level
//  r_address    out  4   regfile read address (card index)
//  r_data       in   12  regfile read data, valid 1 cycle after r_address
//  revealed     out  15  bit i = card i face-up, not yet matched
//  matched      out  15  bit i = card i permanently matched
//  game_over    out  1   high once NUM_PAIRS matches are found
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; all outputs 0; pair count 0; delay counter 0.
//  Click: click = left & ~left_q (registered). Only click edges count; held button = one click.
//  Hit test (comb.): col c if GRID_X0+c*(CARD_W+GAP) <= xpos < that+CARD_W; row similarly in y.
//   idx = row*CARDS_X+col. Gaps/outside grid = no hit. Bounds are half-open.
//  States:
//   IDLE   : enable=1 -> WAIT1. All masks hold 0.
//   WAIT1  : click hits card i with revealed[i]=0 and matched[i]=0 -> set revealed[i];
//            latch idx1; r_address=i; -> RD1. Bit i visible the cycle after the click.
//   RD1    : one cycle; on the next edge, latch color1 <= r_data -> WAIT2.
//   WAIT2  : valid click on a different, unmatched card j -> set revealed[j]; latch idx2;
//            r_address=j; -> RD2. Clicks on idx1, matched cards, or gaps are ignored.
//   RD2    : one cycle -> CMP.
//   CMP    : r_data==color1 -> matched[idx1,idx2]<=1, revealed bits cleared, pairs+1;
//            pairs+1==NUM_PAIRS -> DONE, else WAIT1.
//            Mismatch -> load counter with HIDE_DELAY-1 -> SHOW.
//   SHOW   : decrement counter; at 0, clear revealed[idx1,idx2] -> WAIT1.
//            Clicks are ignored throughout.
//   DONE   : game_over=1; masks hold; stays until enable=0 or reset.
//  Click in RD1/RD2/CMP/SHOW/DONE is dropped, not queued.
//  enable falls in any state -> IDLE next cycle; revealed, matched, pairs, game_over cleared.
//  r_address holds its last value outside RD states; reset value 0.
//  At most 2 revealed bits are set at any time; revealed & matched == 0 always.
// CONFIGURATION
//  Macro CARD_PICK_MOVES_EN:
//   defined   -> extra output moves [7:0]. Increments at every CMP entry and saturates at 255.
//                Cleared by reset and by enable=0.
//   undefined -> no moves port, no counter logic.
// TESTING
//  T1 reset: rst=0 mid-SHOW -> all outputs 0 immediately; after release with enable=1 -> WAIT1.
//  T2 match: colors[0]=colors[6]=12'hF00; click (100,100) then (320,350) ->
//     matched=15'h0041, revealed=0 four cycles after the 2nd click.
//  T3 mismatch: HIDE_DELAY=10; cards 0/1 differ -> revealed=15'h0003 for 10 cycles, then 0,
//     back in WAIT1.
//  T4 ignores: click in gap (215,100), re-click card 0, hold left 50 cycles, click during SHOW
//     -> no mask change, single reveal per press.
//  T5 completion: seven matching pairs -> game_over=1 on the 7th CMP; card 14 unmatched;
//     enable=0 -> all cleared.
//  T6 CARD_PICK_MOVES_EN: 3 mismatches + 1 match -> moves=4; 300 compares -> moves=255.

Source files
------------

// File: rtl/card_pick_controller_if.sv
// Signal bundle between the card-pick game stage and its environment (mouse, regfile, draw_cards).
// Optional moves counter port is present only when CARD_PICK_MOVES_EN is defined.
interface card_pick_controller_if;
  // No valid/ready pairs here: a pick is the one-cycle rising edge of left; r_data is trusted
  // one cycle after r_address changes, and all outputs are plain registered levels.
  logic        enable;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        left;
  logic [3:0]  r_address;
  logic [11:0] r_data;
  logic [14:0] revealed;
  logic [14:0] matched;
  logic        game_over;
  logic [2:0]  state_dbg;
`ifdef CARD_PICK_MOVES_EN
  logic [7:0]  moves;
`endif

  modport slave (
    input  enable, xpos, ypos, left, r_data,
    output r_address, revealed, matched, game_over, state_dbg
`ifdef CARD_PICK_MOVES_EN
    , output moves
`endif
  );

  modport master (
    output enable, xpos, ypos, left, r_data,
    input  r_address, revealed, matched, game_over, state_dbg
`ifdef CARD_PICK_MOVES_EN
    , input moves
`endif
  );
endinterface

// File: rtl/card_pick_controller.sv
// Memory-game pick/compare stage: turns click edges into card picks, compares colours, drives masks.
// Optional macro CARD_PICK_MOVES_EN adds a saturating 8-bit count of compares on bus.moves.
module card_pick_controller #(
  parameter int CARDS_X    = 5,
  parameter int CARDS_Y    = 3,
  parameter int GRID_X0    = 57,
  parameter int GRID_Y0    = 44,
  parameter int CARD_W     = 150,
  parameter int CARD_H     = 200,
  parameter int GAP        = 40,
  parameter int NUM_PAIRS  = 7,
  parameter int HIDE_DELAY = 65000000
) (
  input  logic                    pclk,
  input  logic                    rst,
  card_pick_controller_if.slave   bus
);

  localparam int NCARDS = CARDS_X * CARDS_Y;
  localparam int CNT_W  = (HIDE_DELAY > 1) ? $clog2(HIDE_DELAY) : 1;
  localparam int PAIR_W = $clog2(NUM_PAIRS + 1);
  localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(NUM_PAIRS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT1, S_RD1, S_WAIT2, S_RD2, S_CMP, S_SHOW, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                left_q;
  logic [NCARDS-1:0]   revealed_q, revealed_d;
  logic [NCARDS-1:0]   matched_q, matched_d;
  logic                game_over_q, game_over_d;
  logic [PAIR_W-1:0]   pairs_q, pairs_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          idx1_q, idx1_d;
  logic [3:0]          idx2_q, idx2_d;
  logic [11:0]         color1_q, color1_d;
  logic [3:0]          r_address_q, r_address_d;
`ifdef CARD_PICK_MOVES_EN
  logic [7:0]          moves_q, moves_d;
`endif

  logic       click;
  logic       col_ok, row_ok, hit;
  int         col_n, row_n;
  logic [3:0] hit_idx;

  assign click = bus.left & ~left_q;

  // Half-open hit windows per column/row; anything in a gap or outside the grid is no hit.
  always_comb begin
    col_ok = 1'b0;
    row_ok = 1'b0;
    col_n  = 0;
    row_n  = 0;
    for (int c = 0; c < CARDS_X; c++) begin
      if ({20'd0, bus.xpos} >= 32'(GRID_X0 + c * (CARD_W + GAP)) &&
          {20'd0, bus.xpos} <  32'(GRID_X0 + c * (CARD_W + GAP) + CARD_W)) begin
        col_ok = 1'b1;
        col_n  = c;
      end
    end
    for (int r = 0; r < CARDS_Y; r++) begin
      if ({20'd0, bus.ypos} >= 32'(GRID_Y0 + r * (CARD_H + GAP)) &&
          {20'd0, bus.ypos} <  32'(GRID_Y0 + r * (CARD_H + GAP) + CARD_H)) begin
        row_ok = 1'b1;
        row_n  = r;
      end
    end
    hit     = col_ok & row_ok;
    hit_idx = 4'(row_n * CARDS_X + col_n);
  end

  always_comb begin
    state_d     = state_q;
    revealed_d  = revealed_q;
    matched_d   = matched_q;
    game_over_d = game_over_q;
    pairs_d     = pairs_q;
    cnt_d       = cnt_q;
    idx1_d      = idx1_q;
    idx2_d      = idx2_q;
    color1_d    = color1_q;
    r_address_d = r_address_q;
`ifdef CARD_PICK_MOVES_EN
    moves_d     = moves_q;
`endif
    if (!bus.enable) begin
      state_d     = S_IDLE;
      revealed_d  = '0;
      matched_d   = '0;
      game_over_d = 1'b0;
      pairs_d     = '0;
      cnt_d       = '0;
`ifdef CARD_PICK_MOVES_EN
      moves_d     = 8'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE: state_d = S_WAIT1;
        S_WAIT1: begin
          if (click && hit && !revealed_q[hit_idx] && !matched_q[hit_idx]) begin
            revealed_d[hit_idx] = 1'b1;
            idx1_d              = hit_idx;
            r_address_d         = hit_idx;
            state_d             = S_RD1;
          end
        end
        S_RD1: begin
          color1_d = bus.r_data;
          state_d  = S_WAIT2;
        end
        S_WAIT2: begin
          if (click && hit && (hit_idx != idx1_q) && !matched_q[hit_idx]) begin
            revealed_d[hit_idx] = 1'b1;
            idx2_d              = hit_idx;
            r_address_d         = hit_idx;
            state_d             = S_RD2;
          end
        end
        S_RD2: begin
          state_d = S_CMP;
`ifdef CARD_PICK_MOVES_EN
          if (moves_q != 8'hFF) moves_d = moves_q + 8'd1;
`endif
        end
        S_CMP: begin
          if (bus.r_data == color1_q) begin
            matched_d[idx1_q]  = 1'b1;
            matched_d[idx2_q]  = 1'b1;
            revealed_d[idx1_q] = 1'b0;
            revealed_d[idx2_q] = 1'b0;
            pairs_d            = pairs_q + 1'b1;
            if (pairs_q == LAST_PAIR) begin
              game_over_d = 1'b1;
              state_d     = S_DONE;
            end else begin
              state_d = S_WAIT1;
            end
          end else begin
            cnt_d   = CNT_W'(HIDE_DELAY - 1);
            state_d = S_SHOW;
          end
        end
        S_SHOW: begin
          if (cnt_q == '0) begin
            revealed_d[idx1_q] = 1'b0;
            revealed_d[idx2_q] = 1'b0;
            state_d            = S_WAIT1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      left_q      <= 1'b0;
      revealed_q  <= '0;
      matched_q   <= '0;
      game_over_q <= 1'b0;
      pairs_q     <= '0;
      cnt_q       <= '0;
      idx1_q      <= 4'd0;
      idx2_q      <= 4'd0;
      color1_q    <= 12'd0;
      r_address_q <= 4'd0;
`ifdef CARD_PICK_MOVES_EN
      moves_q     <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      left_q      <= bus.left;
      revealed_q  <= revealed_d;
      matched_q   <= matched_d;
      game_over_q <= game_over_d;
      pairs_q     <= pairs_d;
      cnt_q       <= cnt_d;
      idx1_q      <= idx1_d;
      idx2_q      <= idx2_d;
      color1_q    <= color1_d;
      r_address_q <= r_address_d;
`ifdef CARD_PICK_MOVES_EN
      moves_q     <= moves_d;
`endif
    end
  end

  assign bus.r_address = r_address_q;
  assign bus.revealed  = revealed_q;
  assign bus.matched   = matched_q;
  assign bus.game_over = game_over_q;
  assign bus.state_dbg = state_q;
`ifdef CARD_PICK_MOVES_EN
  assign bus.moves     = moves_q;
`endif

endmodule
